control_pipeline: RTL and testbench
===================================

# control_pipeline

Consumes the ID-stage control bundles (WB, MEM, EX, jump, branch) and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers. It decodes each bundle into per-stage strobes and tracks destination registers. It also produces the load-use stall, the taken-redirect flush and the EX operand forwarding selects. It sits between the opcode decoder and the datapath of the 5-stage MIPS-32 pipeline.

## Interface
- No parameters. Register-number width is fixed at 5, and bundle widths are fixed.
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all stage registers.
- WB_in  in  2  {reg_write, mem_to_reg} of the instruction in ID.
- MEM_in  in  2  {mem_read, mem_write} of the instruction in ID.
- EX_in  in  4  {reg_dest, ALU_Op[1:0], ALU_src} of the instruction in ID.
- jump_in, branch_in  in  1 each  redirect class of the ID instruction: 1/1 = j (unconditional), 1/0 = beq, 0/x = none.
- id_rs_in, id_rt_in, id_rd_in  in  5 each  register fields of the ID instruction.
- zero_in  in  1  ALU zero flag of the instruction currently in EX.
- ex_reg_dest_out  out  1  EX-stage reg_dest strobe.
- ex_ALU_Op_out  out  2  EX-stage ALU_Op.
- ex_ALU_src_out  out  1  EX-stage ALU_src strobe.
- mem_read_out, mem_write_out  out  1 each  MEM-stage strobes.
- wb_reg_write_out, wb_mem_to_reg_out  out  1 each  WB-stage strobes.
- wb_write_reg_out  out  5  WB destination register.
- fwd_a_out, fwd_b_out  out  2 each  EX operand source select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- stall_out  out  1  load-use hazard. Upstream holds PC and IF/ID while it is high.
- flush_out  out  1  taken redirect in EX. Upstream squashes IF/ID and loads the target.

## Operation
- Stage registers:
  - ID/EX holds {WB, MEM, EX, jump, branch, rs, rt, rd}.
  - EX/MEM holds {WB, MEM, write_reg}.
  - MEM/WB holds {WB, write_reg}.
- Bubble: every control bit is 0, and all register fields are 0.
- EX write_reg = ex_reg_dest ? ex_rd : ex_rt. It is computed combinationally and captured into EX/MEM.
- Load-use stall: stall_out = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs_in | ex_rt == id_rt_in).
- Redirect: flush_out = ex_jump & (ex_branch | zero_in).
- ID/EX next value:
  - Bubble if reset, stall_out or flush_out is high.
  - Otherwise the input bundle and register fields.
- Flush and stall are mutually exclusive by construction, because a redirect instruction never has mem_read set. If both are high, the result is still a bubble.
- EX/MEM and MEM/WB always advance; they never stall.
- Forwarding for fwd_a_out (fwd_b_out is identical with ex_rt in place of ex_rs):
  - 10 if EX/MEM reg_write, write_reg != 0 and write_reg == ex_rs.
  - Otherwise 01 if MEM/WB reg_write, write_reg != 0 and write_reg == ex_rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- Register 0 never forwards and never stalls.
- Stage strobe outputs are direct register fields. stall_out, flush_out and fwd_* are combinational from the stage registers and the inputs.

## Timing
- Bundle presented at edge N:
  - EX strobes valid after edge N+1.
  - MEM strobes valid after N+2.
  - WB strobes and wb_write_reg_out valid after N+3.
- stall_out is high for exactly one cycle per load-use pair. The held ID instruction enters EX one edge later, with fwd select 01 from the load in WB.
- flush_out is asserted during the redirect instruction's EX cycle. The following edge loads a bubble into ID/EX.
- Reset, including mid-stream:
  - All three stage registers clear at the reset edge.
  - Every output is 0 after that edge, including stall_out and flush_out.
  - In-flight instructions are discarded.
  - Normal flow resumes with the first bundle sampled on the edge after reset deasserts.

## Test plan
- Reset: hold reset for 2 cycles with an lw bundle on the inputs -> all outputs 0. Deassert reset -> the lw EX strobes appear 1 edge later.
- lw flow: WB=11, MEM=10, EX=0001, rt=5 at edge 0:
  - After edge 1: ex_ALU_src=1.
  - After edge 2: mem_read=1.
  - After edge 3: wb_reg_write=1, wb_mem_to_reg=1, wb_write_reg=5.
- Load-use: lw rt=8, then add rs=8:
  - stall_out=1 for one cycle.
  - The next EX is a bubble (all strobes 0).
  - The add then reaches EX with fwd_a_out=01.
- Forwarding:
  - add rd=3, then sub rs=3 rt=3 -> fwd_a=fwd_b=10.
  - Same sequence with one unrelated instruction in between -> 01.
  - Same sequence with rd=0 -> 00.
- Redirect:
  - beq with zero_in=1 -> flush_out=1 for one cycle, and the next ID/EX is a bubble.
  - beq with zero_in=0 -> flush_out=0.
  - j with zero_in=0 -> flush_out=1.
- Reset mid-stream: assert reset with instructions in all three stages -> all outputs 0 after that edge, and no residual WB write.

Source files
------------

// File: rtl/control_pipeline.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for a 5-stage MIPS-32 core,
// with load-use stall, taken-redirect flush and EX operand forwarding selects.
module control_pipeline (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] WB_in,
  input  logic [1:0] MEM_in,
  input  logic [3:0] EX_in,
  input  logic       jump_in,
  input  logic       branch_in,
  input  logic [4:0] id_rs_in,
  input  logic [4:0] id_rt_in,
  input  logic [4:0] id_rd_in,
  input  logic       zero_in,
  output logic       ex_reg_dest_out,
  output logic [1:0] ex_ALU_Op_out,
  output logic       ex_ALU_src_out,
  output logic       mem_read_out,
  output logic       mem_write_out,
  output logic       wb_reg_write_out,
  output logic       wb_mem_to_reg_out,
  output logic [4:0] wb_write_reg_out,
  output logic [1:0] fwd_a_out,
  output logic [1:0] fwd_b_out,
  output logic       stall_out,
  output logic       flush_out
);

  // ID/EX
  logic [1:0] ex_wb;
  logic [1:0] ex_mem;
  logic [3:0] ex_ctl;
  logic       ex_jump;
  logic       ex_branch;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] ex_rd;

  // EX/MEM
  logic [1:0] mem_wb;
  logic [1:0] mem_mem;
  logic [4:0] mem_write_reg;

  // MEM/WB
  logic [1:0] wb_wb;
  logic [4:0] wb_write_reg;

  logic [4:0] ex_write_reg;
  logic       bubble;

  assign ex_write_reg = ex_ctl[3] ? ex_rd : ex_rt;

  assign stall_out = ex_mem[1] && (ex_rt != '0) &&
                     ((ex_rt == id_rs_in) || (ex_rt == id_rt_in));
  assign flush_out = ex_jump && (ex_branch || zero_in);
  assign bubble    = reset || stall_out || flush_out;

  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_wb     <= '0;
      ex_mem    <= '0;
      ex_ctl    <= '0;
      ex_jump   <= 1'b0;
      ex_branch <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
    end else begin
      ex_wb     <= WB_in;
      ex_mem    <= MEM_in;
      ex_ctl    <= EX_in;
      ex_jump   <= jump_in;
      ex_branch <= branch_in;
      ex_rs     <= id_rs_in;
      ex_rt     <= id_rt_in;
      ex_rd     <= id_rd_in;
    end
  end

  // Downstream stages never stall; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb        <= '0;
      mem_mem       <= '0;
      mem_write_reg <= '0;
      wb_wb         <= '0;
      wb_write_reg  <= '0;
    end else begin
      mem_wb        <= ex_wb;
      mem_mem       <= ex_mem;
      mem_write_reg <= ex_write_reg;
      wb_wb         <= mem_wb;
      wb_write_reg  <= mem_write_reg;
    end
  end

  logic mem_fwd_ok;
  logic wb_fwd_ok;

  assign mem_fwd_ok = mem_wb[1] && (mem_write_reg != '0);
  assign wb_fwd_ok  = wb_wb[1] && (wb_write_reg != '0);

  always_comb begin
    fwd_a_out = 2'b00;
    if (mem_fwd_ok && (mem_write_reg == ex_rs))
      fwd_a_out = 2'b10;
    else if (wb_fwd_ok && (wb_write_reg == ex_rs))
      fwd_a_out = 2'b01;
  end

  always_comb begin
    fwd_b_out = 2'b00;
    if (mem_fwd_ok && (mem_write_reg == ex_rt))
      fwd_b_out = 2'b10;
    else if (wb_fwd_ok && (wb_write_reg == ex_rt))
      fwd_b_out = 2'b01;
  end

  assign ex_reg_dest_out   = ex_ctl[3];
  assign ex_ALU_Op_out     = ex_ctl[2:1];
  assign ex_ALU_src_out    = ex_ctl[0];
  assign mem_read_out      = mem_mem[1];
  assign mem_write_out     = mem_mem[0];
  assign wb_reg_write_out  = wb_wb[1];
  assign wb_mem_to_reg_out = wb_wb[0];
  assign wb_write_reg_out  = wb_write_reg;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: directed instruction sequences push
// expected per-cycle output values, a negedge checker pops and compares them.
module tb_control_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] WB_in, MEM_in;
  logic [3:0] EX_in;
  logic       jump_in, branch_in, zero_in;
  logic [4:0] id_rs_in, id_rt_in, id_rd_in;
  logic       ex_reg_dest_out, ex_ALU_src_out;
  logic [1:0] ex_ALU_Op_out;
  logic       mem_read_out, mem_write_out;
  logic       wb_reg_write_out, wb_mem_to_reg_out;
  logic [4:0] wb_write_reg_out;
  logic [1:0] fwd_a_out, fwd_b_out;
  logic       stall_out, flush_out;

  control_pipeline dut (
    .clk(clk), .reset(reset),
    .WB_in(WB_in), .MEM_in(MEM_in), .EX_in(EX_in),
    .jump_in(jump_in), .branch_in(branch_in),
    .id_rs_in(id_rs_in), .id_rt_in(id_rt_in), .id_rd_in(id_rd_in),
    .zero_in(zero_in),
    .ex_reg_dest_out(ex_reg_dest_out), .ex_ALU_Op_out(ex_ALU_Op_out),
    .ex_ALU_src_out(ex_ALU_src_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_reg_write_out(wb_reg_write_out), .wb_mem_to_reg_out(wb_mem_to_reg_out),
    .wb_write_reg_out(wb_write_reg_out),
    .fwd_a_out(fwd_a_out), .fwd_b_out(fwd_b_out),
    .stall_out(stall_out), .flush_out(flush_out)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_REG_DEST, S_ALU_OP, S_ALU_SRC, S_MEM_READ, S_MEM_WRITE, S_WB_REG_WRITE,
    S_MEM_TO_REG, S_WREG, S_FWD_A, S_FWD_B, S_STALL, S_FLUSH
  } sel_e;

  typedef struct {
    int   at;
    sel_e sel;
    int   val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  function automatic int dut_val(input sel_e s);
    case (s)
      S_REG_DEST:     return int'(ex_reg_dest_out);
      S_ALU_OP:       return int'(ex_ALU_Op_out);
      S_ALU_SRC:      return int'(ex_ALU_src_out);
      S_MEM_READ:     return int'(mem_read_out);
      S_MEM_WRITE:    return int'(mem_write_out);
      S_WB_REG_WRITE: return int'(wb_reg_write_out);
      S_MEM_TO_REG:   return int'(wb_mem_to_reg_out);
      S_WREG:         return int'(wb_write_reg_out);
      S_FWD_A:        return int'(fwd_a_out);
      S_FWD_B:        return int'(fwd_b_out);
      S_STALL:        return int'(stall_out);
      default:        return int'(flush_out);
    endcase
  endfunction

  // Compare every expectation due in this cycle; stale ones count as failures.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        check_eq($sformatf("%s@%0d", sb[i].sel.name(), cyc), dut_val(sb[i].sel), sb[i].val);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        check_eq($sformatf("stale_%s@%0d", sb[i].sel.name(), sb[i].at), -1, sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_val(input int at, input sel_e s, input int v);
    exp_t e;
    e.at = at; e.sel = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int at);
    for (int s = 0; s <= int'(S_FLUSH); s++) expect_val(at, sel_e'(s), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
                       input logic j, input logic b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    WB_in = wb; MEM_in = mem; EX_in = ex; jump_in = j; branch_in = b;
    id_rs_in = rs; id_rt_in = rt; id_rd_in = rd;
    tick();
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
    issue(2'b11, 2'b10, 4'b0001, 1'b0, 1'b0, rs, rt, 5'd0);
  endtask
  task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    issue(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, rs, rt, rd);
  endtask
  task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
    issue(2'b00, 2'b00, 4'b0010, 1'b1, 1'b0, rs, rt, 5'd0);
  endtask
  task automatic jmp();
    issue(2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic nop();
    issue(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic drain();
    for (int k = 0; k < 3; k++) nop();
  endtask

  initial begin
    int t;
    reset = 1'b1;
    zero_in = 1'b0;
    WB_in = 2'b11; MEM_in = 2'b10; EX_in = 4'b0001; jump_in = 1'b0; branch_in = 1'b0;
    id_rs_in = 5'd0; id_rt_in = 5'd5; id_rd_in = 5'd0;

    // Reset held two cycles with an lw on the inputs
    expect_zero(1);
    expect_zero(2);
    tick();
    tick();
    reset = 1'b0;
    t = cyc;
    expect_val(t + 1, S_ALU_SRC, 1);
    expect_val(t + 1, S_REG_DEST, 0);
    expect_val(t + 1, S_ALU_OP, 0);
    expect_val(t + 2, S_MEM_READ, 1);
    expect_val(t + 2, S_MEM_WRITE, 0);
    expect_val(t + 3, S_WB_REG_WRITE, 1);
    expect_val(t + 3, S_MEM_TO_REG, 1);
    expect_val(t + 3, S_WREG, 5);
    lw(5'd0, 5'd5);
    drain();

    // Load-use: lw r8 then add using r8 (held by upstream during the stall)
    t = cyc;
    lw(5'd0, 5'd8);
    expect_val(t + 1, S_STALL, 1);
    add(5'd8, 5'd2, 5'd9);
    expect_val(t + 2, S_STALL, 0);
    expect_val(t + 2, S_REG_DEST, 0);
    expect_val(t + 2, S_ALU_OP, 0);
    expect_val(t + 2, S_ALU_SRC, 0);
    add(5'd8, 5'd2, 5'd9);
    expect_val(t + 3, S_REG_DEST, 1);
    expect_val(t + 3, S_FWD_A, 1);
    expect_val(t + 3, S_FWD_B, 0);
    drain();

    // Forward from EX/MEM, plus rd writeback through reg_dest mux
    t = cyc;
    add(5'd1, 5'd2, 5'd3);
    add(5'd3, 5'd3, 5'd4);
    expect_val(t + 2, S_FWD_A, 2);
    expect_val(t + 2, S_FWD_B, 2);
    expect_val(t + 3, S_WREG, 3);
    expect_val(t + 3, S_WB_REG_WRITE, 1);
    expect_val(t + 3, S_MEM_TO_REG, 0);
    drain();

    // Forward from MEM/WB with one unrelated instruction between
    t = cyc;
    add(5'd1, 5'd2, 5'd3);
    nop();
    add(5'd3, 5'd3, 5'd4);
    expect_val(t + 3, S_FWD_A, 1);
    expect_val(t + 3, S_FWD_B, 1);
    drain();

    // Register 0 never forwards
    t = cyc;
    add(5'd1, 5'd2, 5'd0);
    add(5'd0, 5'd0, 5'd4);
    expect_val(t + 2, S_FWD_A, 0);
    expect_val(t + 2, S_FWD_B, 0);
    drain();

    // EX/MEM wins over MEM/WB for the same register
    t = cyc;
    add(5'd1, 5'd2, 5'd3);
    add(5'd4, 5'd5, 5'd3);
    add(5'd3, 5'd3, 5'd6);
    expect_val(t + 3, S_FWD_A, 2);
    expect_val(t + 3, S_FWD_B, 2);
    drain();

    // Taken beq: flush, squashed follower never reaches WB
    t = cyc;
    beq(5'd1, 5'd2);
    zero_in = 1'b1;
    expect_val(t + 1, S_FLUSH, 1);
    expect_val(t + 1, S_ALU_OP, 1);
    add(5'd1, 5'd2, 5'd7);
    expect_val(t + 2, S_FLUSH, 0);
    expect_val(t + 2, S_ALU_OP, 0);
    expect_val(t + 2, S_REG_DEST, 0);
    expect_val(t + 4, S_WB_REG_WRITE, 0);
    nop();
    zero_in = 1'b0;
    drain();

    // Not-taken beq: follower proceeds
    t = cyc;
    beq(5'd1, 5'd2);
    expect_val(t + 1, S_FLUSH, 0);
    add(5'd1, 5'd2, 5'd7);
    expect_val(t + 2, S_ALU_OP, 2);
    expect_val(t + 2, S_REG_DEST, 1);
    expect_val(t + 4, S_WREG, 7);
    drain();

    // Unconditional jump flushes regardless of zero
    t = cyc;
    jmp();
    expect_val(t + 1, S_FLUSH, 1);
    nop();
    expect_val(t + 2, S_FLUSH, 0);
    drain();

    // Reset with all three stages occupied
    t = cyc;
    lw(5'd0, 5'd5);
    add(5'd1, 5'd2, 5'd6);
    add(5'd1, 5'd2, 5'd7);
    expect_val(t + 3, S_WB_REG_WRITE, 1);
    expect_val(t + 3, S_WREG, 5);
    expect_val(t + 3, S_REG_DEST, 1);
    reset = 1'b1;
    add(5'd1, 5'd2, 5'd8);
    expect_zero(t + 4);
    reset = 1'b0;
    expect_val(t + 5, S_WB_REG_WRITE, 0);
    expect_val(t + 5, S_WREG, 0);
    expect_val(t + 5, S_MEM_READ, 0);
    expect_val(t + 6, S_WB_REG_WRITE, 0);
    expect_val(t + 6, S_WREG, 0);
    nop();
    drain();
    tick();

    @(negedge clk);
    #1;
    check_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
